// File: rtl/pipe_cpu_pkg.sv
// Shared encoding, instruction classes and pipeline control records for pipe_cpu_fwd.
package pipe_cpu_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam int OP_LSB = 26;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;
    localparam int IMM_W  = 16;

    typedef enum logic [2:0] {
        CL_RR, CL_RI, CL_LOAD, CL_STORE, CL_BRANCH, CL_HALT, CL_NOP
    } iclass_t;

    typedef enum logic [1:0] {FWD_RF, FWD_MEM, FWD_WB} fwd_t;

    // Control half of ID/EX; data fields are added at use where XLEN is known.
    // rs/rt are zero when the instruction does not read them, dst is zero when it writes nothing.
    typedef struct packed {
        logic       valid;
        iclass_t    cls;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
    } ex_ctl_t;

    // Control half of EX/MEM and MEM/WB.
    typedef struct packed {
        logic       valid;
        iclass_t    cls;
        logic [4:0] dst;
    } wb_ctl_t;

    function automatic iclass_t decode(logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return CL_RR;
            OP_ADDI, OP_SUBI, OP_SLTI:                      return CL_RI;
            OP_LW:                                          return CL_LOAD;
            OP_SW:                                          return CL_STORE;
            OP_BNEQZ, OP_BEQZ:                              return CL_BRANCH;
            OP_HLT:                                         return CL_HALT;
            default:                                        return CL_NOP;
        endcase
    endfunction

    function automatic logic [4:0] reg_map(logic [4:0] r, int nreg);
        return 5'(32'(r) % nreg);
    endfunction

endpackage

// File: rtl/pipe_cpu_hazard.sv
// Forward selection, load-use stall and branch flush for the 5-stage core (purely combinational).
module pipe_cpu_hazard
    import pipe_cpu_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] ex_dst,
    input  logic       mem_valid,
    input  logic [4:0] mem_dst,
    input  logic       wb_valid,
    input  logic [4:0] wb_dst,
    input  logic       br_taken,
    output fwd_t       fwd_a,
    output fwd_t       fwd_b,
    output logic       stall,
    output logic       flush
);

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (mem_valid && mem_dst != '0 && mem_dst == ex_rs)
            fwd_a = FWD_MEM;
        else if (wb_valid && wb_dst != '0 && wb_dst == ex_rs)
            fwd_a = FWD_WB;
        if (mem_valid && mem_dst != '0 && mem_dst == ex_rt)
            fwd_b = FWD_MEM;
        else if (wb_valid && wb_dst != '0 && wb_dst == ex_rt)
            fwd_b = FWD_WB;

        flush = br_taken;
        // A taken branch squashes the waiting consumer, so the stall is dropped.
        stall = !br_taken && id_valid && ex_valid && ex_is_load && ex_dst != '0 &&
                (ex_dst == id_rs || ex_dst == id_rt);
    end

endmodule

// File: rtl/pipe_cpu_fwd.sv
// 5-stage pipelined core with operand forwarding, load-use interlock and branch flush.
module pipe_cpu_fwd
    import pipe_cpu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_wdata,
    input  logic [4:0]                    dbg_raddr,
    output logic [XLEN-1:0]               dbg_rdata,
    output logic                          halted,
    output logic [31:0]                   retired
);

    localparam int PCW = $clog2(IMEM_DEPTH);
    localparam int AW  = $clog2(DMEM_DEPTH);

    typedef struct packed {
        ex_ctl_t         ctl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [PCW-1:0]  pc;
    } idex_t;

    typedef struct packed {
        wb_ctl_t         ctl;
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] sdata;
    } exmem_t;

    typedef struct packed {
        wb_ctl_t         ctl;
        logic [XLEN-1:0] res;
    } memwb_t;

    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];
    logic [XLEN-1:0] regs [32];

    logic [PCW-1:0] pc;
    logic           fetch_stop;
    logic           ifid_valid;
    logic [31:0]    ifid_instr;
    logic [PCW-1:0] ifid_pc;
    idex_t          idex, id_nxt;
    exmem_t         exmem, ex_nxt;
    memwb_t         memwb, mem_nxt;

    logic            id_halt, stall, flush, br_taken;
    logic [PCW-1:0]  br_target;
    fwd_t            fwd_a, fwd_b;
    logic [XLEN-1:0] fa, fb, ex_res;
    logic [5:0]      id_op;
    logic [4:0]      id_rs_f, id_rt_f, id_rd_f, dbg_idx;

    always_ff @(posedge clk) begin
        if (!run && imem_we)
            imem[imem_addr] <= imem_wdata;
    end

    // ID: decode and register read, with write-through from the instruction in WB
    always_comb begin
        id_op   = ifid_instr[OP_LSB +: 6];
        id_rs_f = reg_map(ifid_instr[RS_LSB +: 5], NREG);
        id_rt_f = reg_map(ifid_instr[RT_LSB +: 5], NREG);
        id_rd_f = reg_map(ifid_instr[RD_LSB +: 5], NREG);
        id_nxt           = '0;
        id_nxt.ctl.valid = ifid_valid;
        id_nxt.ctl.cls   = decode(id_op);
        id_nxt.ctl.op    = id_op;
        id_nxt.pc        = ifid_pc;
        id_nxt.imm       = {{(XLEN-IMM_W){ifid_instr[IMM_W-1]}}, ifid_instr[IMM_W-1:0]};
        case (id_nxt.ctl.cls)
            CL_RR:           begin id_nxt.ctl.rs = id_rs_f; id_nxt.ctl.rt = id_rt_f; id_nxt.ctl.dst = id_rd_f; end
            CL_RI, CL_LOAD:  begin id_nxt.ctl.rs = id_rs_f; id_nxt.ctl.dst = id_rt_f; end
            CL_STORE:        begin id_nxt.ctl.rs = id_rs_f; id_nxt.ctl.rt = id_rt_f; end
            CL_BRANCH:       id_nxt.ctl.rs = id_rs_f;
            default:         ;
        endcase
        id_nxt.a = regs[id_nxt.ctl.rs];
        if (memwb.ctl.valid && memwb.ctl.dst == id_nxt.ctl.rs)
            id_nxt.a = memwb.res;
        if (id_nxt.ctl.rs == '0)
            id_nxt.a = '0;
        id_nxt.b = regs[id_nxt.ctl.rt];
        if (memwb.ctl.valid && memwb.ctl.dst == id_nxt.ctl.rt)
            id_nxt.b = memwb.res;
        if (id_nxt.ctl.rt == '0)
            id_nxt.b = '0;
        id_halt = ifid_valid && id_nxt.ctl.cls == CL_HALT;
    end

    pipe_cpu_hazard u_hazard (
        .id_valid   (ifid_valid),
        .id_rs      (id_nxt.ctl.rs),
        .id_rt      (id_nxt.ctl.rt),
        .ex_valid   (idex.ctl.valid),
        .ex_is_load (idex.ctl.cls == CL_LOAD),
        .ex_rs      (idex.ctl.rs),
        .ex_rt      (idex.ctl.rt),
        .ex_dst     (idex.ctl.dst),
        .mem_valid  (exmem.ctl.valid),
        .mem_dst    (exmem.ctl.dst),
        .wb_valid   (memwb.ctl.valid),
        .wb_dst     (memwb.ctl.dst),
        .br_taken   (br_taken),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall      (stall),
        .flush      (flush)
    );

    always_comb begin
        fa = (fwd_a == FWD_MEM) ? exmem.res : (fwd_a == FWD_WB) ? memwb.res : idex.a;
        fb = (fwd_b == FWD_MEM) ? exmem.res : (fwd_b == FWD_WB) ? memwb.res : idex.b;
        ex_res = '0;
        case (idex.ctl.cls)
            CL_RR: begin
                case (idex.ctl.op)
                    OP_ADD:  ex_res = fa + fb;
                    OP_SUB:  ex_res = fa - fb;
                    OP_AND:  ex_res = fa & fb;
                    OP_OR:   ex_res = fa | fb;
                    OP_SLT:  ex_res = XLEN'($signed(fa) < $signed(fb));
                    OP_MUL:  ex_res = fa * fb;
                    default: ex_res = '0;
                endcase
            end
            CL_RI: begin
                case (idex.ctl.op)
                    OP_SUBI: ex_res = fa - idex.imm;
                    OP_SLTI: ex_res = XLEN'($signed(fa) < $signed(idex.imm));
                    default: ex_res = fa + idex.imm;
                endcase
            end
            CL_LOAD, CL_STORE: ex_res = fa + idex.imm;
            default:           ex_res = '0;
        endcase
        br_taken  = idex.ctl.valid && idex.ctl.cls == CL_BRANCH &&
                    ((idex.ctl.op == OP_BEQZ && fa == '0) || (idex.ctl.op == OP_BNEQZ && fa != '0));
        br_target = idex.pc + PCW'(1) + idex.imm[PCW-1:0];
        ex_nxt           = '0;
        ex_nxt.ctl.valid = idex.ctl.valid;
        ex_nxt.ctl.cls   = idex.ctl.cls;
        ex_nxt.ctl.dst   = idex.ctl.dst;
        ex_nxt.res       = ex_res;
        ex_nxt.sdata     = fb;
        mem_nxt     = '0;
        mem_nxt.ctl = exmem.ctl;
        mem_nxt.res = (exmem.ctl.cls == CL_LOAD) ? dmem[exmem.res[AW-1:0]] : exmem.res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= '0;
            fetch_stop <= 1'b0;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            idex       <= '0;
            exmem      <= '0;
            memwb      <= '0;
            halted     <= 1'b0;
            retired    <= '0;
        end else if (run) begin
            if (flush)
                pc <= br_target;
            else if (!(stall || id_halt || fetch_stop))
                pc <= pc + PCW'(1);
            if (id_halt && !flush)
                fetch_stop <= 1'b1;
            if (flush || (!stall && (id_halt || fetch_stop))) begin
                ifid_valid <= 1'b0;
            end else if (!stall) begin
                ifid_valid <= 1'b1;
                ifid_instr <= imem[pc];
                ifid_pc    <= pc;
            end
            idex <= id_nxt;
            if (flush || stall)
                idex.ctl.valid <= 1'b0;
            exmem <= ex_nxt;
            memwb <= mem_nxt;
            if (memwb.ctl.valid)
                retired <= retired + 32'd1;
            if (memwb.ctl.valid && memwb.ctl.cls == CL_HALT)
                halted <= 1'b1;
        end
    end

    // Entries at or above NREG are never written and stay zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (run && memwb.ctl.valid && memwb.ctl.dst != '0) begin
            regs[memwb.ctl.dst] <= memwb.res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DMEM_DEPTH; i++)
                dmem[i] <= '0;
        end else if (run && exmem.ctl.valid && exmem.ctl.cls == CL_STORE) begin
            dmem[exmem.res[AW-1:0]] <= exmem.sdata;
        end
    end

    always_comb begin
        dbg_idx   = reg_map(dbg_raddr, NREG);
        dbg_rdata = (dbg_idx == '0) ? '0 : regs[dbg_idx];
    end

endmodule

// File: tb/tb_pipe_cpu_fwd.sv
// Directed-program bench for pipe_cpu_fwd: a 32-bit core and a 64-bit/16-register core share stimulus.
module tb_pipe_cpu_fwd;
    import pipe_cpu_pkg::*;

    localparam logic [31:0] HLT_WORD = 32'hfc000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b0;
    logic        imem_we = 1'b0;
    logic [5:0]  imem_addr = '0;
    logic [31:0] imem_wdata = '0;
    logic [4:0]  dbg_raddr = '0;
    logic [31:0] dbg_rdata, retired, retired64;
    logic [63:0] dbg_rdata64;
    logic        halted, halted64;

    int tests = 0;
    int fails = 0;
    int cyc, cyc_b;
    logic [31:0] prog[$];

    always #5 clk = ~clk;

    pipe_cpu_fwd u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .halted(halted), .retired(retired)
    );

    pipe_cpu_fwd #(.XLEN(64), .NREG(16)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .run(run), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata64),
        .halted(halted64), .retired(retired64)
    );

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_r(logic [5:0] op, int rs, int rt, int rd);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'b0};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input int r, input logic [63:0] exp);
        dbg_raddr = 5'(r);
        #1;
        check(tag, 64'(dbg_rdata), exp);
    endtask

    task automatic check_reg64(input string tag, input int r, input logic [63:0] exp);
        dbg_raddr = 5'(r);
        #1;
        check(tag, dbg_rdata64, exp);
    endtask

    task automatic load_prog();
        run = 1'b0;
        for (int i = 0; i < 64; i++) begin
            imem_we    = 1'b1;
            imem_addr  = 6'(i);
            imem_wdata = (i < prog.size()) ? prog[i] : HLT_WORD;
            @(posedge clk);
            #1;
        end
        imem_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(output int cycles);
        run = 1'b1;
        cycles = 0;
        while (!halted && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        run = 1'b0;
        check("halt_reached", 64'(halted), 64'd1);
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        #2;
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_retired", 64'(retired), 64'd0);
        rst_n = 1'b1;

        // Dependent ALU chain without NOPs
        prog = {32'h2801000a, 32'h28020014, 32'h28030019, 32'h00222000, 32'h00832800, 32'hfc000000};
        load_prog();
        do_reset();
        run_to_halt(cyc);
        check("chain_cycles", 64'(cyc), 64'd10);
        check("chain_retired", 64'(retired), 64'd6);
        check_reg("chain_r1", 1, 64'd10);
        check_reg("chain_r2", 2, 64'd20);
        check_reg("chain_r3", 3, 64'd25);
        check_reg("chain_r4", 4, 64'd30);
        check_reg("chain_r5", 5, 64'd55);
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run = 1'b0;
        check("chain_retired_hold", 64'(retired), 64'd6);
        check("chain_halted_hold", 64'(halted), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst2_halted", 64'(halted), 64'd0);
        check("rst2_retired", 64'(retired), 64'd0);
        check_reg("rst2_r5", 5, 64'd0);
        rst_n = 1'b1;

        // Load-use interlock versus the same program with no load
        prog = {enc_i(OP_ADDI, 0, 1, 85), enc_i(OP_SW, 0, 1, 4), enc_i(OP_LW, 0, 2, 4),
                enc_r(OP_ADD, 2, 2, 3), HLT_WORD};
        load_prog();
        do_reset();
        run_to_halt(cyc);
        check("lu_cycles", 64'(cyc), 64'd10);
        check("lu_retired", 64'(retired), 64'd5);
        check_reg("lu_r2", 2, 64'd85);
        check_reg("lu_r3", 3, 64'd170);
        prog[2] = enc_i(OP_ADDI, 0, 2, 85);
        load_prog();
        do_reset();
        run_to_halt(cyc_b);
        check("nolu_cycles", 64'(cyc_b), 64'd9);
        check_reg("nolu_r3", 3, 64'd170);

        // Taken branch skips two instructions
        prog = {enc_i(OP_ADDI, 0, 1, 0), enc_i(OP_BEQZ, 1, 0, 2), enc_i(OP_ADDI, 0, 2, 99),
                enc_i(OP_ADDI, 0, 3, 99), enc_i(OP_ADDI, 0, 4, 7), HLT_WORD};
        load_prog();
        do_reset();
        run_to_halt(cyc);
        check("beqz_cycles", 64'(cyc), 64'd10);
        check("beqz_retired", 64'(retired), 64'd4);
        check_reg("beqz_r2", 2, 64'd0);
        check_reg("beqz_r3", 3, 64'd0);
        check_reg("beqz_r4", 4, 64'd7);

        // Same program, branch not taken
        prog[1] = enc_i(OP_BNEQZ, 1, 0, 2);
        load_prog();
        do_reset();
        run_to_halt(cyc);
        check("bneqz_cycles", 64'(cyc), 64'd10);
        check("bneqz_retired", 64'(retired), 64'd6);
        check_reg("bneqz_r2", 2, 64'd99);
        check_reg("bneqz_r3", 3, 64'd99);
        check_reg("bneqz_r4", 4, 64'd7);

        // HLT in the shadow of a taken branch is squashed
        prog = {enc_i(OP_BEQZ, 0, 0, 1), HLT_WORD, enc_i(OP_ADDI, 0, 5, 3), HLT_WORD};
        load_prog();
        do_reset();
        run_to_halt(cyc);
        check("shadow_cycles", 64'(cyc), 64'd9);
        check("shadow_retired", 64'(retired), 64'd3);
        check_reg("shadow_r5", 5, 64'd3);

        // 64-bit datapath, 16 registers
        prog = {enc_i(OP_SUBI, 0, 1, 1), enc_i(OP_SLTI, 1, 2, 0), enc_r(OP_MUL, 1, 1, 3), HLT_WORD};
        load_prog();
        do_reset();
        run_to_halt(cyc);
        check("x64_halted", 64'(halted64), 64'd1);
        check("x64_retired", 64'(retired64), 64'd4);
        check_reg64("x64_r1", 1, 64'hFFFF_FFFF_FFFF_FFFF);
        check_reg64("x64_r2", 2, 64'd1);
        check_reg64("x64_r3", 3, 64'd1);
        check_reg64("x64_r17_wraps", 17, 64'hFFFF_FFFF_FFFF_FFFF);
        check_reg("x32_r1", 1, 64'h0000_0000_FFFF_FFFF);
        check_reg("x32_r3", 3, 64'd1);

        // Reset asserted mid-run, then rerun from pc 0 with imem intact
        prog = {32'h2801000a, 32'h28020014, 32'h28030019, 32'h00222000, 32'h00832800, 32'hfc000000};
        load_prog();
        do_reset();
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_halted", 64'(halted), 64'd0);
        check("mid_retired", 64'(retired), 64'd0);
        for (int r = 1; r <= 5; r++)
            check_reg($sformatf("mid_r%0d", r), r, 64'd0);
        rst_n = 1'b1;
        run_to_halt(cyc);
        check("rerun_cycles", 64'(cyc), 64'd10);
        check("rerun_retired", 64'(retired), 64'd6);
        check_reg("rerun_r4", 4, 64'd30);
        check_reg("rerun_r5", 5, 64'd55);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_cpu_fwd.md
Name: pipe_cpu_fwd

Overview:
- Next-generation 5-stage pipelined CPU core (IF/ID/EX/MEM/WB). Same 32-bit instruction encoding and opcode set as the current two-phase core.
- Runs on one clock, with a parametrised data width and register/memory depths.
- Adds operand forwarding, a load-use interlock and branch flush, so programs need no software NOPs between dependent instructions.
- Instruction memory loads through ports, so benches no longer need hierarchical pokes.

Parameters:
- XLEN, 32, data/register width; legal values 32 or 64. Immediates sign-extend to XLEN.
- NREG, 32, number of registers; legal values 2..32. R0 is hardwired to zero. Register specifiers index modulo NREG.
- IMEM_DEPTH, 64, instruction words; power of 2.
- DMEM_DEPTH, 64, data words (XLEN each); power of 2.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = execute; 0 = pipeline frozen, imem load permitted
- imem_we  in  1  instruction write strobe; ignored while run=1
- imem_addr  in  $clog2(IMEM_DEPTH)  instruction write address
- imem_wdata  in  32  instruction word
- dbg_raddr  in  5  register debug read address
- dbg_rdata  out  XLEN  combinational register read; R0 reads 0
- halted  out  1  HLT has retired
- retired  out  32  count of instructions reaching WB; wraps

Behaviour:
- Encoding: op[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
  - RR ops (rd←rs op rt): ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100 (signed), MUL 000101 (low XLEN bits).
  - RI ops (rt←rs op imm): ADDI 001010, SUBI 001011, SLTI 001100.
  - LW 001000: rt←dmem[rs+imm]. SW 001001: dmem[rs+imm]←rt.
  - BNEQZ 001101 and BEQZ 001110 test rs.
  - HLT 111111.
  - Any other opcode executes as a NOP but still counts as retired.
- Addressing: word-addressed. PC wraps modulo IMEM_DEPTH. Data address = low $clog2(DMEM_DEPTH) bits of rs+imm.
- Reset (async, rst_n=0):
  - pc=0; all pipeline valid bits 0; registers 0; halted=0; retired=0.
  - dmem is cleared. imem is preserved.
- Progress: with run=1 and halted=0, one instruction issues per cycle. Result is written in WB, 4 cycles after fetch. run=0 holds every state element.
- Register file: a WB write is visible to an ID read in the same cycle (write-through). Writes to R0 are discarded.
- Forwarding: EX operands take the youngest matching producer, in priority EX/MEM > MEM/WB > register file. Matching uses the destination register and valid bit; R0 never forwards.
- Load-use interlock: if the instruction in EX is LW with rt matching a source of the instruction in ID:
  - stall exactly 1 cycle: hold pc and IF/ID, inject a bubble into EX;
  - the bubble is not counted in retired.
- Branch, resolved in EX: taken when (BEQZ and rs==0) or (BNEQZ and rs!=0), using the forwarded rs.
  - Taken: next pc = branch_pc+1+imm; flush IF/ID and ID/EX (2 bubbles).
  - Not taken: no penalty.
  - If a load-use stall and a taken branch occur in the same cycle, the branch flush wins.
- HLT:
  - When HLT is decoded in ID, fetch stops: pc holds and IF/ID is invalidated.
  - Older instructions drain normally.
  - halted=1 in the cycle after HLT's WB and stays set until reset.
  - An HLT in a branch shadow is flushed and has no effect.
- imem writes: take effect at the clock edge when run=0 and imem_we=1.

Decomposition:
- Package pipe_cpu_pkg holds:
  - opcode localparams;
  - instruction-class enum (RR, RI, LOAD, STORE, BRANCH, HALT, NOP);
  - field bit positions;
  - pipeline-register struct typedefs, parameterised via XLEN at use.
- Sub-module pipe_cpu_hazard: purely combinational. Inputs are ID sources and EX/MEM/WB destinations and valids. Outputs are forward selects, stall and flush.
- Everything else, including the pipeline registers, stays in pipe_cpu_fwd.

Test Plan:
- Dependent ALU chain, no NOPs. Preload 2801000a, 28020014, 28030019, 00222000, 00832800, fc000000; pulse rst_n; run=1.
  - Expect R1=10, R2=20, R3=25, R4=30, R5=55.
  - Expect halted high 10 cycles after run, retired=6.
- Load-use. Program: ADDI R1,R0,85; SW R1,4(R0); LW R2,4(R0); ADD R3,R2,R2; HLT.
  - Expect R3=170.
  - Expect halted exactly 1 cycle later than the same program with LW replaced by ADDI R2,R0,85.
- Branch. Program: ADDI R1,R0,0; BEQZ R1,+2; ADDI R2,R0,99; ADDI R3,R0,99; ADDI R4,R0,7; HLT.
  - Expect R2=R3=0, R4=7, retired=4.
  - Repeat with BNEQZ: expect R2=R3=99, retired=6.
- HLT in branch shadow. Program: BEQZ R0,+1; HLT; ADDI R5,R0,3; HLT.
  - Expect R5=3; first HLT has no effect.
- XLEN=64, NREG=16. Program: SUBI R1,R0,1; SLTI R2,R1,0; MUL R3,R1,R1.
  - Expect R1=64'hFFFF_FFFF_FFFF_FFFF, R2=1, R3=1.
- Reset mid-run. Drop rst_n during the chain test at cycle 3.
  - Expect immediately: halted=0, retired=0, all registers 0.
  - After release, the program reruns from pc 0 with the same results (imem intact).
